// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state encoding,
// the x0 register index, the per-stage control bundle and a saturating increment helper.
package pipe_hazard_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } hz_state_e;

  localparam logic [4:0] RegX0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifde_stall;
    logic ifde_flush;
    logic deal_stall;
    logic deal_flush;
    logic alumem_stall;
    logic memwb_bubble;
  } hz_ctrl_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (&val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator between the DE and ALU stages.
// A load whose destination is x0 never creates a hazard.
module pipe_hazard_detect
  import pipe_hazard_pkg::*;
(
  input  logic [4:0] de_rs1_i,
  input  logic [4:0] de_rs2_i,
  input  logic       de_use_rs1_i,
  input  logic       de_use_rs2_i,
  input  logic       alu_load_i,
  input  logic [4:0] alu_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = de_use_rs1_i & (de_rs1_i == alu_rd_i);
  assign rs2_hit    = de_use_rs2_i & (de_rs2_i == alu_rd_i);
  assign load_use_o = alu_load_i & (alu_rd_i != RegX0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: memory-wait FSM with watchdog,
// priority mux (memstall > redirect > load-use). Optional HAZARD_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  i_DeRs1_5,
  input  logic [4:0]  i_DeRs2_5,
  input  logic        i_DeUseRs1_1,
  input  logic        i_DeUseRs2_1,
  input  logic        i_AluLoad_1,
  input  logic [4:0]  i_AluRd_5,
  input  logic        i_Redirect_1,
  input  logic        i_MemReq_1,
  input  logic        i_MemReady_1,
  output logic        o_PcStall_1,
  output logic        o_IfDeStall_1,
  output logic        o_IfDeFlush_1,
  output logic        o_DeAluStall_1,
  output logic        o_DeAluFlush_1,
  output logic        o_AluMemStall_1,
  output logic        o_MemWbBubble_1,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] o_LoadUseCnt_32,
  output logic [31:0] o_RedirectCnt_32,
  output logic [31:0] o_MemWaitCnt_32,
`endif
  output logic        o_MemTimeout_1
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             load_use;
  logic             mem_stall;
  logic             mem_active;
  hz_ctrl_t         ctrl;

  pipe_hazard_detect u_detect (
    .de_rs1_i     (i_DeRs1_5),
    .de_rs2_i     (i_DeRs2_5),
    .de_use_rs1_i (i_DeUseRs1_1),
    .de_use_rs2_i (i_DeUseRs2_1),
    .alu_load_i   (i_AluLoad_1),
    .alu_rd_i     (i_AluRd_5),
    .load_use_o   (load_use)
  );

  assign mem_stall  = i_MemReq_1 & ~i_MemReady_1;
  assign mem_active = (state_q == StMemWait) | mem_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StMemWait: begin
        if (i_MemReady_1) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (!i_MemReq_1) begin
          // Request withdrawn without completion: abandon the wait and flag it.
          state_d   = StRun;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
    if ((state_d == StMemWait) && (cnt_d == CNT_W'(MEM_TIMEOUT))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Frozen ALU stage re-presents redirect/load-use after the memory wait ends.
  always_comb begin
    ctrl = '0;
    if (mem_active) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.ifde_stall   = 1'b1;
      ctrl.deal_stall   = 1'b1;
      ctrl.alumem_stall = 1'b1;
      ctrl.memwb_bubble = ~i_MemReady_1;
    end else if (i_Redirect_1) begin
      ctrl.ifde_flush = 1'b1;
      ctrl.deal_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifde_stall = 1'b1;
      ctrl.deal_flush = 1'b1;
    end
    if (!rstn) begin
      ctrl = '0;
    end
  end

  assign o_PcStall_1     = ctrl.pc_stall;
  assign o_IfDeStall_1   = ctrl.ifde_stall;
  assign o_IfDeFlush_1   = ctrl.ifde_flush;
  assign o_DeAluStall_1  = ctrl.deal_stall;
  assign o_DeAluFlush_1  = ctrl.deal_flush;
  assign o_AluMemStall_1 = ctrl.alumem_stall;
  assign o_MemWbBubble_1 = ctrl.memwb_bubble;
  assign o_MemTimeout_1  = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;

  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    redir_cnt_d = redir_cnt_q;
    mem_cnt_d   = mem_cnt_q;
    if (mem_active) begin
      mem_cnt_d = sat_inc32(mem_cnt_q);
    end else if (i_Redirect_1) begin
      redir_cnt_d = sat_inc32(redir_cnt_q);
    end else if (load_use) begin
      lu_cnt_d = sat_inc32(lu_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lu_cnt_q    <= '0;
      redir_cnt_q <= '0;
      mem_cnt_q   <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
    end
  end

  assign o_LoadUseCnt_32  = lu_cnt_q;
  assign o_RedirectCnt_32 = redir_cnt_q;
  assign o_MemWaitCnt_32  = mem_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4); expected output vectors are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_pipe_hazard_ctrl;

  // Output vector: {pc, ifde_st, ifde_fl, deal_st, deal_fl, alumem_st, bubble, timeout}
  localparam logic [7:0] Idle = 8'b0000_0000;
  localparam logic [7:0] Lu   = 8'b1100_1000;
  localparam logic [7:0] Rd   = 8'b0010_1000;
  localparam logic [7:0] Ms   = 8'b1101_0110;
  localparam logic [7:0] Mr   = 8'b1101_0100;
  localparam logic [7:0] To   = 8'b0000_0001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       load;
    logic [4:0] rd;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  de_rs1 = '0;
  logic [4:0]  de_rs2 = '0;
  logic        de_use1 = 1'b0;
  logic        de_use2 = 1'b0;
  logic        alu_load = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic        redirect = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_stall, ifde_stall, ifde_flush, deal_stall, deal_flush;
  logic        alumem_stall, memwb_bubble, mem_timeout;
  logic [7:0]  outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt, redir_cnt, mem_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_DeRs1_5        (de_rs1),
    .i_DeRs2_5        (de_rs2),
    .i_DeUseRs1_1     (de_use1),
    .i_DeUseRs2_1     (de_use2),
    .i_AluLoad_1      (alu_load),
    .i_AluRd_5        (alu_rd),
    .i_Redirect_1     (redirect),
    .i_MemReq_1       (mem_req),
    .i_MemReady_1     (mem_ready),
    .o_PcStall_1      (pc_stall),
    .o_IfDeStall_1    (ifde_stall),
    .o_IfDeFlush_1    (ifde_flush),
    .o_DeAluStall_1   (deal_stall),
    .o_DeAluFlush_1   (deal_flush),
    .o_AluMemStall_1  (alumem_stall),
    .o_MemWbBubble_1  (memwb_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .o_LoadUseCnt_32  (lu_cnt),
    .o_RedirectCnt_32 (redir_cnt),
    .o_MemWaitCnt_32  (mem_cnt),
`endif
    .o_MemTimeout_1   (mem_timeout)
  );

  assign outs = {pc_stall, ifde_stall, ifde_flush, deal_stall, deal_flush,
                 alumem_stall, memwb_bubble, mem_timeout};

  function automatic step_t mk(input int rs1, input int rs2, input int u1, input int u2,
                               input int ld, input int rd, input int rdr, input int rq,
                               input int ry, input logic [7:0] exp);
    step_t s;
    s.rs1   = 5'(rs1);
    s.rs2   = 5'(rs2);
    s.use1  = (u1 != 0);
    s.use2  = (u2 != 0);
    s.load  = (ld != 0);
    s.rd    = 5'(rd);
    s.redir = (rdr != 0);
    s.req   = (rq != 0);
    s.rdy   = (ry != 0);
    s.exp   = exp;
    return s;
  endfunction

  task automatic drive_step(input step_t s, input string nm);
    de_rs1    = s.rs1;
    de_rs2    = s.rs2;
    de_use1   = s.use1;
    de_use2   = s.use2;
    alu_load  = s.load;
    alu_rd    = s.rd;
    redirect  = s.redir;
    mem_req   = s.req;
    mem_ready = s.rdy;
    exp_q.push_back(s.exp);
    name_q.push_back(nm);
  endtask

  task automatic drive_idle();
    de_rs1 = '0; de_rs2 = '0; de_use1 = 1'b0; de_use2 = 1'b0; alu_load = 1'b0;
    alu_rd = '0; redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    step_t steps[$];
    rstn = 1'b0;
    // Every hazard source active while in reset.
    drive_step(mk(5, 0, 1, 0, 1, 5, 1, 1, 0, Idle), "reset_async");
    #1;
    exp = exp_q.pop_front(); void'(name_q.pop_front());
    checks++;
    if (outs !== exp) begin
      errors++; $display("FAIL reset_async: got %b expected %b", outs, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_held: got %b expected %b", outs, 8'h00);
    end
    drive_idle();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle));
    foreach (steps[i]) begin
      drive_step(steps[i], "reset_release");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [7:0] exp;
    step_t steps[$];
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 0, 0, 0, Lu));    // lw x5; add x6,x5,x1
    steps.push_back(mk(5, 1, 1, 1, 0, 6, 0, 0, 0, Idle));  // load moved on to MEM
    steps.push_back(mk(2, 7, 1, 1, 1, 7, 0, 0, 0, Lu));    // rs2 match
    steps.push_back(mk(2, 7, 1, 0, 1, 7, 0, 0, 0, Idle));  // rs2 match, not read
    steps.push_back(mk(3, 4, 1, 1, 1, 9, 0, 0, 0, Idle));  // no match
    steps.push_back(mk(9, 4, 1, 1, 0, 9, 0, 0, 0, Idle));  // match but not a load
    steps.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, Idle));  // lw x0
    foreach (steps[i]) begin
      drive_step(steps[i], "load_use");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    logic [7:0] exp;
    step_t steps[$];
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 0, 0, Rd));    // redirect beats load-use
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, Rd));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Idle));  // single-cycle access
    foreach (steps[i]) begin
      drive_step(steps[i], "redirect");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait_redirect();
    logic [7:0] exp;
    step_t steps[$];
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 1, 0, Ms));
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 1, 0, Ms));
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 1, 0, Ms));
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 1, 1, Mr));
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 1, 0, 0, Rd));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle));
    foreach (steps[i]) begin
      drive_step(steps[i], "mem_wait_redirect");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    step_t steps[$];
    // Each wait ends at counter 3; a counter that failed to restart would hit 4.
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 3; k++) steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms));
      steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Mr));
    end
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle));
    foreach (steps[i]) begin
      drive_step(steps[i], "back_to_back");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] exp;
    step_t steps[$];
    for (int k = 0; k < 4; k++) steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms | To));   // counter = 4
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms | To));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Mr | To));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, Rd | To));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle | To));
    foreach (steps[i]) begin
      drive_step(steps[i], "watchdog");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] exp;
    step_t steps[$];
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms | To));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms | To));
    foreach (steps[i]) begin
      drive_step(steps[i], "pre_reset_wait");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (outs !== 8'h00) begin
      errors++; $display("FAIL reset_mid_wait_async: got %b expected %b", outs, 8'h00);
    end
    drive_idle();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({lu_cnt, redir_cnt, mem_cnt} !== 96'd0) begin
      errors++; $display("FAIL perf_after_reset: got %0d %0d %0d expected 0 0 0",
                         lu_cnt, redir_cnt, mem_cnt);
    end
`endif
    steps.delete();
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle));  // state back in RUN, flag clear
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 0, 0, 0, Lu));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, Rd));
    for (int k = 0; k < 2; k++) steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, Mr));
    foreach (steps[i]) begin
      drive_step(steps[i], "post_reset");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (lu_cnt !== 32'd1 || redir_cnt !== 32'd1 || mem_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_counts: got %0d %0d %0d expected 1 1 3",
                         lu_cnt, redir_cnt, mem_cnt);
    end
`endif
  endtask

  task automatic test_protocol_violation();
    logic [7:0] exp;
    step_t steps[$];
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Ms));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Ms));        // request dropped in MEM_WAIT
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Idle | To));
    steps.push_back(mk(5, 1, 1, 1, 1, 5, 0, 0, 0, Lu | To));
    foreach (steps[i]) begin
      drive_step(steps[i], "protocol_violation");
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s step %0d: got %b expected %b", name_q.pop_front(), i, outs, exp);
      end else void'(name_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait_redirect();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_wait();
    test_protocol_violation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
